// File: rtl/midi_voice_allocator.sv
// Polyphonic MIDI voice allocator: routes note, sustain and all-notes-off events to NUM_VOICES
// voices, with oldest-note stealing and a forced gate-low gap on retrigger or steal.
module midi_voice_allocator #(
    parameter int NUM_VOICES    = 8,
    parameter int CHANNEL       = 0,
    parameter bit OMNI          = 1'b0,
    parameter int RETRIG_CYCLES = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    midi_event_valid,
    input  logic [7:0]              midi_command,
    input  logic [6:0]              midi_parameter_1,
    input  logic [6:0]              midi_parameter_2,
    output logic                    midi_event_ack,
    input  logic [NUM_VOICES-1:0]   voice_idle,
    output logic [NUM_VOICES-1:0]   voice_gate,
    output logic [7*NUM_VOICES-1:0] voice_note,
    output logic [7*NUM_VOICES-1:0] voice_velocity,
    output logic [2:0]              o_dbg_state
);
    localparam int IW = $clog2(NUM_VOICES);
    localparam int GW = $clog2(RETRIG_CYCLES + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_VOICES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(RETRIG_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_GAP, S_APPLY, S_HOLDOFF} state_t;
    typedef enum logic [2:0] {OP_NOP, OP_ON, OP_OFF, OP_PEDAL, OP_ANO} op_t;

    // Handshake: the producer holds midi_event_valid and the event fields stable until it sees
    // the one-cycle midi_event_ack pulse, then drops valid within one cycle (HOLDOFF covers that).
    state_t                r_state, w_state_nxt;
    op_t                   r_op, w_op;
    logic [6:0]            r_p1, r_p2;
    logic [IW-1:0]         r_scan, r_target, r_match_idx, r_free_idx, r_old_idx;
    logic                  r_match_found, r_free_found;
    logic [GW-1:0]         r_gap_cnt;
    logic [NUM_VOICES-1:0] r_gate, r_sus;
    logic [6:0]            r_note [NUM_VOICES];
    logic [6:0]            r_vel  [NUM_VOICES];
    logic [IW-1:0]         r_rank [NUM_VOICES];
    logic                  r_pedal, r_ack;

    logic                  w_chan_ok, w_hold_k, w_match_k, w_free_k;
    logic                  w_match_found, w_free_found;
    logic [IW-1:0]         w_match_idx, w_free_idx, w_old_idx, w_target;

    assign w_chan_ok = OMNI || (midi_command[3:0] == 4'(CHANNEL));

    always_comb begin
        w_op = OP_NOP;
        case (midi_command[7:4])
            4'h9: w_op = (midi_parameter_2 != 7'd0) ? OP_ON : OP_OFF;
            4'h8: w_op = OP_OFF;
            4'hB: begin
                if (midi_parameter_1 == 7'd64)       w_op = OP_PEDAL;
                else if (midi_parameter_1 == 7'd123) w_op = OP_ANO;
            end
            default: w_op = OP_NOP;
        endcase
        if (!w_chan_ok) w_op = OP_NOP;
    end

    // Running scan result including the voice examined this cycle; valid as the target on the last scan cycle.
    assign w_hold_k      = r_gate[r_scan] | r_sus[r_scan];
    assign w_match_k     = w_hold_k && (r_note[r_scan] == r_p1);
    assign w_free_k      = voice_idle[r_scan] && !r_gate[r_scan];
    assign w_match_found = r_match_found | w_match_k;
    assign w_match_idx   = r_match_found ? r_match_idx : r_scan;
    assign w_free_found  = r_free_found | w_free_k;
    assign w_free_idx    = r_free_found ? r_free_idx : r_scan;
    assign w_old_idx     = (r_rank[r_scan] == LAST_IDX) ? r_scan : r_old_idx;
    assign w_target      = w_match_found ? w_match_idx : (w_free_found ? w_free_idx : w_old_idx);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (midi_event_valid) w_state_nxt = (w_op == OP_ON) ? S_SCAN : S_APPLY;
            S_SCAN:    if (r_scan == LAST_IDX) w_state_nxt = r_gate[w_target] ? S_GAP : S_APPLY;
            S_GAP:     if (r_gap_cnt == GAP_LAST) w_state_nxt = S_APPLY;
            S_APPLY:   w_state_nxt = S_HOLDOFF;
            S_HOLDOFF: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack         <= 1'b0;
            r_gate        <= '0;
            r_sus         <= '0;
            r_pedal       <= 1'b0;
            r_op          <= OP_NOP;
            r_p1          <= '0;
            r_p2          <= '0;
            r_scan        <= '0;
            r_target      <= '0;
            r_match_idx   <= '0;
            r_free_idx    <= '0;
            r_old_idx     <= '0;
            r_match_found <= 1'b0;
            r_free_found  <= 1'b0;
            r_gap_cnt     <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_note[i] <= '0;
                r_vel[i]  <= '0;
                r_rank[i] <= IW'(i);
            end
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_IDLE: if (midi_event_valid) begin
                    r_op          <= w_op;
                    r_p1          <= midi_parameter_1;
                    r_p2          <= midi_parameter_2;
                    r_scan        <= '0;
                    r_match_found <= 1'b0;
                    r_free_found  <= 1'b0;
                    r_gap_cnt     <= '0;
                end
                S_SCAN: begin
                    r_scan        <= r_scan + 1'b1;
                    r_match_found <= w_match_found;
                    r_match_idx   <= w_match_idx;
                    r_free_found  <= w_free_found;
                    r_free_idx    <= w_free_idx;
                    r_old_idx     <= w_old_idx;
                    r_target      <= w_target;
                end
                S_GAP: begin
                    r_gate[r_target] <= 1'b0;
                    r_gap_cnt        <= r_gap_cnt + 1'b1;
                end
                S_APPLY: begin
                    r_ack <= 1'b1;
                    case (r_op)
                        OP_ON: begin
                            r_gate[r_target] <= 1'b1;
                            r_sus[r_target]  <= 1'b0;
                            r_note[r_target] <= r_p1;
                            r_vel[r_target]  <= r_p2;
                            for (int i = 0; i < NUM_VOICES; i++) begin
                                if (IW'(i) == r_target)                r_rank[i] <= '0;
                                else if (r_rank[i] < r_rank[r_target]) r_rank[i] <= r_rank[i] + 1'b1;
                            end
                        end
                        OP_OFF: begin
                            for (int i = 0; i < NUM_VOICES; i++) begin
                                if ((r_gate[i] | r_sus[i]) && (r_note[i] == r_p1)) begin
                                    if (r_pedal) r_sus[i]  <= 1'b1;
                                    else         r_gate[i] <= 1'b0;
                                end
                            end
                        end
                        OP_PEDAL: begin
                            r_pedal <= r_p2[6];
                            // Pedal release frees every voice whose note-off arrived while held.
                            if (r_pedal && !r_p2[6]) begin
                                for (int i = 0; i < NUM_VOICES; i++) begin
                                    if (r_sus[i]) begin
                                        r_gate[i] <= 1'b0;
                                        r_sus[i]  <= 1'b0;
                                    end
                                end
                            end
                        end
                        OP_ANO: begin
                            r_gate <= '0;
                            r_sus  <= '0;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
        assign voice_note[7*g +: 7]     = r_note[g];
        assign voice_velocity[7*g +: 7] = r_vel[g];
    end

    assign voice_gate     = r_gate;
    assign midi_event_ack = r_ack;
    assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_midi_voice_allocator.sv
// Bench for midi_voice_allocator: directed scenarios plus random events, checked every cycle
// against an event-level model that tracks voices and note age as a recency queue.
module tb_midi_voice_allocator;
    localparam int N = 4;
    localparam int R = 4;
    localparam int OP_NOP = 0, OP_ON = 1, OP_OFF = 2, OP_PEDAL = 3, OP_ANO = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           midi_event_valid = 1'b0;
    logic [7:0]     midi_command = '0;
    logic [6:0]     midi_parameter_1 = '0;
    logic [6:0]     midi_parameter_2 = '0;
    logic           midi_event_ack;
    logic [N-1:0]   voice_idle = '1;
    logic [N-1:0]   voice_gate;
    logic [7*N-1:0] voice_note;
    logic [7*N-1:0] voice_velocity;
    logic [2:0]     dbg_state;

    always #5 clk = ~clk;

    midi_voice_allocator #(
        .NUM_VOICES(N), .CHANNEL(0), .OMNI(1'b0), .RETRIG_CYCLES(R)
    ) dut (
        .clk(clk), .rst(rst),
        .midi_event_valid(midi_event_valid), .midi_command(midi_command),
        .midi_parameter_1(midi_parameter_1), .midi_parameter_2(midi_parameter_2),
        .midi_event_ack(midi_event_ack), .voice_idle(voice_idle),
        .voice_gate(voice_gate), .voice_note(voice_note),
        .voice_velocity(voice_velocity), .o_dbg_state(dbg_state)
    );

    // Behavioural model: age_q holds voice indices, most recently started first.
    bit   [N-1:0]   m_gate, m_sus;
    logic [6:0]     m_note [N];
    logic [6:0]     m_vel  [N];
    bit             m_pedal, m_ack;
    int             age_q[$];
    logic [7*N-1:0] exp_note, exp_vel;

    int  n_checks = 0;
    int  n_pass   = 0;
    bit  chk_en   = 1'b0;
    int  lat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_gate  = '0;
        m_sus   = '0;
        m_pedal = 1'b0;
        m_ack   = 1'b0;
        age_q.delete();
        for (int i = 0; i < N; i++) begin
            m_note[i] = '0;
            m_vel[i]  = '0;
            age_q.push_back(i);
        end
    endtask

    function automatic int classify(input logic [7:0] c, input logic [6:0] a, input logic [6:0] b);
        if (c[3:0] != 4'd0) return OP_NOP;
        if (c[7:4] == 4'h9 && b != 7'd0) return OP_ON;
        if (c[7:4] == 4'h9 || c[7:4] == 4'h8) return OP_OFF;
        if (c[7:4] == 4'hB && a == 7'd64) return OP_PEDAL;
        if (c[7:4] == 4'hB && a == 7'd123) return OP_ANO;
        return OP_NOP;
    endfunction

    function automatic int pick_target(input logic [6:0] note);
        for (int i = 0; i < N; i++)
            if ((m_gate[i] || m_sus[i]) && m_note[i] == note) return i;
        for (int i = 0; i < N; i++)
            if (voice_idle[i] && !m_gate[i]) return i;
        return age_q[age_q.size()-1];
    endfunction

    task automatic model_apply(input int op, input logic [6:0] a, input logic [6:0] b, input int t);
        int pos;
        case (op)
            OP_ON: begin
                m_gate[t] = 1'b1;
                m_sus[t]  = 1'b0;
                m_note[t] = a;
                m_vel[t]  = b;
                pos = 0;
                for (int j = 0; j < age_q.size(); j++) if (age_q[j] == t) pos = j;
                age_q.delete(pos);
                age_q.push_front(t);
            end
            OP_OFF: begin
                for (int i = 0; i < N; i++) begin
                    if ((m_gate[i] || m_sus[i]) && m_note[i] == a) begin
                        if (m_pedal) m_sus[i]  = 1'b1;
                        else         m_gate[i] = 1'b0;
                    end
                end
            end
            OP_PEDAL: begin
                if (m_pedal && b < 7'd64) begin
                    for (int i = 0; i < N; i++) begin
                        if (m_sus[i]) begin
                            m_gate[i] = 1'b0;
                            m_sus[i]  = 1'b0;
                        end
                    end
                end
                m_pedal = (b >= 7'd64);
            end
            OP_ANO: begin
                m_gate = '0;
                m_sus  = '0;
            end
            default: ;
        endcase
    endtask

    // Called at a negedge with voice_idle already set; returns the model's accept-to-ack latency.
    task automatic run_event(input logic [7:0] c, input logic [6:0] a, input logic [6:0] b, output int l);
        int op;
        int tgt;
        bit gap;
        op  = classify(c, a, b);
        tgt = 0;
        gap = 1'b0;
        midi_command     = c;
        midi_parameter_1 = a;
        midi_parameter_2 = b;
        midi_event_valid = 1'b1;
        if (op == OP_ON) begin
            tgt = pick_target(a);
            gap = m_gate[tgt];
            l   = N + 1 + (gap ? R : 0);
        end else begin
            l = 1;
        end
        @(posedge clk);
        for (int e = 1; e <= l; e++) begin
            @(posedge clk);
            if (gap && e == N + 1) m_gate[tgt] = 1'b0;
            if (e == l) begin
                model_apply(op, a, b, tgt);
                m_ack = 1'b1;
            end
        end
        @(negedge clk);
        midi_event_valid = 1'b0;
        @(posedge clk);
        m_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < N; i++) begin
                exp_note[7*i +: 7] = m_note[i];
                exp_vel[7*i +: 7]  = m_vel[i];
            end
            check("gate", 64'(voice_gate), 64'(m_gate));
            check("note", 64'(voice_note), 64'(exp_note));
            check("velocity", 64'(voice_velocity), 64'(exp_vel));
            check("ack", 64'(midi_event_ack), 64'(m_ack));
        end
    end

    initial begin
        int kind;
        logic [7:0] c;
        logic [6:0] a, b;

        repeat (2) @(posedge clk);
        model_reset();
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("pin_reset_gate", 64'(voice_gate), 64'd0);

        // First note lands on voice 0 with no gap.
        voice_idle = 4'b1111;
        run_event(8'h90, 7'h3C, 7'h64, lat);
        check("pin_first_lat", 64'(lat), 64'd5);
        check("pin_first_gate", 64'(voice_gate), 64'b0001);
        check("pin_first_note", 64'(voice_note[6:0]), 64'h3C);
        check("pin_first_vel", 64'(voice_velocity[6:0]), 64'h64);

        // Fill all voices, then steal the oldest.
        do_reset();
        voice_idle = 4'b1111;
        run_event(8'h90, 7'h3C, 7'h64, lat);
        run_event(8'h90, 7'h40, 7'h50, lat);
        run_event(8'h90, 7'h43, 7'h40, lat);
        run_event(8'h90, 7'h48, 7'h30, lat);
        voice_idle = 4'b0000;
        run_event(8'h90, 7'h4A, 7'h20, lat);
        check("pin_steal_lat", 64'(lat), 64'd9);
        check("pin_steal_gate", 64'(voice_gate), 64'b1111);
        check("pin_steal_notes", 64'(voice_note), 64'({7'h48, 7'h43, 7'h40, 7'h4A}));

        // Retrigger of a held note.
        run_event(8'h90, 7'h40, 7'h11, lat);
        check("pin_retrig_lat", 64'(lat), 64'd9);
        check("pin_retrig_notes", 64'(voice_note), 64'({7'h48, 7'h43, 7'h40, 7'h4A}));
        check("pin_retrig_vel1", 64'(voice_velocity[13:7]), 64'h11);

        // Sustain pedal holds a released note until the pedal lifts.
        do_reset();
        voice_idle = 4'b1111;
        run_event(8'h90, 7'h3C, 7'h64, lat);
        run_event(8'hB0, 7'h40, 7'h7F, lat);
        run_event(8'h80, 7'h3C, 7'h00, lat);
        check("pin_sus_gate", 64'(voice_gate), 64'b0001);
        run_event(8'hB0, 7'h40, 7'h00, lat);
        check("pin_pedal_up_gate", 64'(voice_gate), 64'b0000);

        // Foreign channel is acked with no effect; velocity-0 note-on releases.
        run_event(8'h91, 7'h3C, 7'h64, lat);
        check("pin_chan_lat", 64'(lat), 64'd1);
        run_event(8'h90, 7'h3C, 7'h64, lat);
        check("pin_hold_gate", 64'(voice_gate), 64'b0001);
        run_event(8'h90, 7'h3C, 7'h00, lat);
        check("pin_vel0_gate", 64'(voice_gate), 64'b0000);
        check("pin_vel0_note_kept", 64'(voice_note[6:0]), 64'h3C);

        // Reset during the scan abandons the event; the held request completes afterwards.
        voice_idle       = 4'b1111;
        midi_command     = 8'h90;
        midi_parameter_1 = 7'h45;
        midi_parameter_2 = 7'h50;
        midi_event_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        check("pin_rst_gate", 64'(voice_gate), 64'd0);
        run_event(8'h90, 7'h45, 7'h50, lat);
        check("pin_rst_retry_gate", 64'(voice_gate), 64'b0001);
        check("pin_rst_retry_note", 64'(voice_note[6:0]), 64'h45);

        for (int it = 0; it < 300; it++) begin
            kind = $urandom_range(0, 99);
            voice_idle = 4'($urandom_range(0, 15));
            c = 8'h90;
            a = 7'($urandom_range(60, 66));
            b = 7'($urandom_range(1, 127));
            if ($urandom_range(0, 19) == 0) a = 7'd0;
            if (kind < 45)      c = 8'h90;
            else if (kind < 55) b = 7'd0;
            else if (kind < 75) c = 8'h80;
            else if (kind < 85) begin c = 8'hB0; a = 7'd64; b = 7'($urandom_range(0, 127)); end
            else if (kind < 88) begin c = 8'hB0; a = 7'd123; end
            else if (kind < 92) begin c = 8'hB0; a = 7'($urandom_range(0, 127)); end
            else if (kind < 96) c = {4'h9, 4'($urandom_range(1, 15))};
            else                c = 8'hA0;
            run_event(c, a, b, lat);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected completion before 2 ms");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/midi_voice_allocator.md
Name: midi_voice_allocator

Overview:
- Parametrised polyphonic MIDI voice allocator. Consumes framed MIDI events from midi_uart over a valid/ack handshake.
- Drives per-voice gate, note and velocity to N voice_fixed_param instances. Frequency lookup stays outside the block.
- Adds features the fixed 8-voice player lacks: configurable voice count, channel filtering, velocity-0 note-off, sustain pedal, all-notes-off, oldest-note voice stealing, and a guaranteed gate-low retrigger gap.

Parameters:
- NUM_VOICES, 8, number of voices (2..32).
- CHANNEL, 0, MIDI channel accepted (0..15).
- OMNI, 0, 1 = accept all channels.
- RETRIG_CYCLES, 32, clk cycles gate is held low before reasserting on a retrigger or steal (>=1).

Ports:
- clk  in  1  system clock (16 MHz).
- rst  in  1  synchronous active-high reset. Single clock domain; all state updates on posedge clk.
- midi_event_valid  in  1  event present; held until ack.
- midi_command  in  8  status byte.
- midi_parameter_1  in  7  note / controller number.
- midi_parameter_2  in  7  velocity / controller value.
- midi_event_ack  out  1  one-cycle pulse when event consumed.
- voice_idle  in  NUM_VOICES  per-voice envelope idle.
- voice_gate  out  NUM_VOICES  per-voice gate.
- voice_note  out  7*NUM_VOICES  note of voice i at [7i+6:7i].
- voice_velocity  out  7*NUM_VOICES  velocity of voice i, latched at note-on.

Behaviour:
- Reset: all outputs 0. Internal per-voice sustained flags 0; sustain pedal 0; age rank of voice i = i; FSM in IDLE.
- rst mid-operation: abandons the event with no ack. The producer keeps valid high, so the event is re-processed after reset.
- Voice "holds" a note when voice_gate=1 or its sustained flag=1. Note value 0 is a legal note; no sentinel.
- Event is sampled only in IDLE, on an edge with midi_event_valid=1 (the accept edge).
- Channel mismatch (OMNI=0 and command[3:0]!=CHANNEL), or an unsupported command: ack with no state change.
- Note-on (9x, vel>0):
  - IDLE -> SCAN, which lasts NUM_VOICES cycles and examines voice k on cycle k.
  - Target priority: (1) the voice already holding the same note (retrigger); (2) the lowest-index voice with voice_idle=1 and gate=0; (3) the voice with the largest age rank (steal).
  - If the target gate=1: GAP state. The target gate drops at the first GAP edge and stays low RETRIG_CYCLES cycles. Then APPLY.
  - Otherwise go straight to APPLY.
  - APPLY edge: target gate=1, note/velocity loaded, sustained flag cleared.
  - Age update: voices with rank < the target's old rank get rank+1; target rank=0. Ranks remain a permutation of 0..N-1.
- Note-on with vel=0 is treated as note-off.
- Note-off (8x): IDLE -> APPLY. Every voice holding that note gets gate=0 if pedal=0; if pedal=1, it keeps gate and sets sustained=1.
- CC 64 (Bx, p1=64): pedal = (p2>=64). A 1->0 transition clears gate and sustained on all sustained voices.
- CC 123 (all notes off): all gates 0, all sustained 0, pedal unchanged.
- Ack timing: midi_event_ack is registered high on the APPLY edge for exactly one cycle. Next edge enters HOLDOFF (1 cycle), then IDLE. The producer must drop valid within 1 cycle of seeing ack.
- Latency from accept edge to outputs/ack:
  - note-on with no gap: NUM_VOICES+1 edges;
  - note-on with gap: NUM_VOICES+1+RETRIG_CYCLES edges;
  - other events: 1 edge.
- voice_note and voice_velocity persist after gate-off, so the release tail keeps its pitch.
- GAP counter width is clog2(RETRIG_CYCLES+1). Rank width is clog2(NUM_VOICES).

Test Plan:
All tests use NUM_VOICES=4, RETRIG_CYCLES=4, CHANNEL=0, OMNI=0, voice_idle driven by the bench.
- Reset, then note-on 90 3C 64 with all idle -> ack at accept+5. voice_gate=0001, voice_note[0]=0x3C, velocity[0]=0x64.
- Four note-ons 3C,40,43,48, then note-on 4A with voice_idle=0000 -> voice 0 (oldest) gate low for 4 cycles, then high with note 4A. Ack at accept+9.
- Note-on 40 while voice 1 already holds 40 -> voice 1 retriggered with a 4-cycle low gap. No other voice changes.
- CC B0 40 7F, then note-off 80 3C 00 -> voice 0 gate stays 1. Then CC B0 40 00 -> voice 0 gate 0.
- Note-on 91 3C 64 (channel 1) -> ack after 1 cycle, outputs unchanged. Note-on 90 3C 00 on a held note -> that voice gate 0.
- Assert rst in SCAN state -> no ack, all outputs 0. Event re-accepted after reset and completes normally.
